// File: rtl/mux_sel_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mux_sel_arbiter_if
//  Description : Bundle connecting the round-robin select arbiter to its
//                requesters, the 8-bit 4:1 multiplexer it steers, and the
//                downstream valid/ready consumer.
//
//  Signals
//    req      [3:0] : per-channel request, bit i selects mux input i
//    mux_val  [7:0] : ValOut of the multiplexer under control of sel
//    ready          : downstream accepts data_out when valid & ready
//    sel      [1:0] : registered multiplexer select
//    grant    [3:0] : one-hot current grant, 0 when nothing is granted
//    valid          : data_out holds a beat
//    data_out [7:0] : registered copy of mux_val for the granted channel
//
//  Modports
//    master : the arbiter itself (drives sel/grant/valid/data_out)
//    slave  : the surrounding system (drives req/mux_val/ready)
//
//  Revision    : 1.0 - initial release
// ============================================================================
interface mux_sel_arbiter_if;

    logic [3:0] req;
    logic [7:0] mux_val;
    logic       ready;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       valid;
    logic [7:0] data_out;

    modport master (
        input  req,
        input  mux_val,
        input  ready,
        output sel,
        output grant,
        output valid,
        output data_out
    );

    modport slave (
        output req,
        output mux_val,
        output ready,
        input  sel,
        input  grant,
        input  valid,
        input  data_out
    );

endinterface
`default_nettype wire

// File: rtl/mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mux_sel_arbiter
//  Description : Round-robin source arbiter for an 8-bit 4:1 multiplexer.
//                One requester is granted at a time; sel steers the mux to
//                it, and the mux output is registered into a valid/ready
//                stream as a burst of up to BURST_LEN beats per grant.
//                A single SETUP cycle (valid low) separates consecutive
//                grants so the mux can settle on the new select.
//
//  Parameters
//    BURST_LEN      : maximum accepted beats per grant, legal range 1..15
//
//  Ports
//    clk            : sole clock, rising edge
//    rst            : asynchronous, active-high reset
//    bus (master)   : req/mux_val/ready in, sel/grant/valid/data_out out
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_sel_arbiter #(
    parameter int BURST_LEN = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mux_sel_arbiter_if.master  bus
);

    // Beat counter is 4 bits wide; BURST_LEN <= 15 keeps the compare exact
    // and the counter can never wrap before it matches.
    localparam logic [3:0] C_BURST_LEN = 4'(BURST_LEN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2
    } state_t;

    state_t     r_state;
    logic [1:0] r_sel;
    logic [3:0] r_grant;
    logic       r_valid;
    logic [7:0] r_data;
    logic [1:0] r_last;     // index of the most recently granted channel
    logic [3:0] r_cnt;      // beats accepted in the current grant

    logic [1:0] w_win;
    logic [3:0] w_win_onehot;
    logic       w_any_req;
    logic       w_accept;
    logic [3:0] w_cnt_inc;
    logic       w_final;

    // ------------------------------------------------------------------------
    // Round-robin pick: search (last+1), (last+2), ... wrapping modulo 4.
    // The fourth probe lands on 'last' itself so a sole requester can be
    // re-granted after its own burst.
    // ------------------------------------------------------------------------
    function automatic logic [1:0] f_pick(input logic [3:0] req,
                                          input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign w_any_req    = |bus.req;
    assign w_win        = f_pick(bus.req, r_last);
    assign w_win_onehot = 4'b0001 << w_win;

    // In XFER valid is always high, so an accept is simply valid & ready.
    assign w_accept  = r_valid && bus.ready;
    assign w_cnt_inc = r_cnt + 4'd1;

    // The beat being accepted is the last of the grant when the burst limit
    // is reached or the granted requester has withdrawn. Looking at req only
    // at accept time means a drop during SETUP or during a stall still lets
    // the pending beat through.
    assign w_final = (w_cnt_inc == C_BURST_LEN) || !bus.req[r_sel];

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sel   <= 2'b00;
            r_grant <= 4'b0000;
            r_valid <= 1'b0;
            r_data  <= 8'h00;
            r_last  <= 2'd3;        // channel 0 gets first priority
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // sel keeps its last value while idle
                    if (w_any_req) begin
                        r_grant <= w_win_onehot;
                        r_sel   <= w_win;
                        r_last  <= w_win;
                        r_state <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    // mux has had a full cycle on the new select
                    r_data  <= bus.mux_val;
                    r_valid <= 1'b1;
                    r_cnt   <= 4'd0;
                    r_state <= ST_XFER;
                end

                ST_XFER: begin
                    // Without an accept everything holds (stall).
                    if (w_accept) begin
                        r_cnt <= w_cnt_inc;
                        if (w_final) begin
                            r_valid <= 1'b0;
                            if (w_any_req) begin
                                r_grant <= w_win_onehot;
                                r_sel   <= w_win;
                                r_last  <= w_win;
                                r_state <= ST_SETUP;
                            end else begin
                                r_grant <= 4'b0000;
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_data <= bus.mux_val;
                        end
                    end
                end

                default: begin
                    r_valid <= 1'b0;
                    r_grant <= 4'b0000;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sel      = r_sel;
    assign bus.grant    = r_grant;
    assign bus.valid    = r_valid;
    assign bus.data_out = r_data;

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_sel_arbiter
//  Description : Directed self-checking bench for mux_sel_arbiter. Two
//                instances share clk/rst: one with BURST_LEN = 4 and one
//                with BURST_LEN = 1. A behavioural 4:1 mux feeds each
//                instance's mux_val from its own sel.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_sel_arbiter;

    logic clk;
    logic rst;
    logic [7:0] mux_in [4];

    int n_chk;
    int n_err;

    mux_sel_arbiter_if bus4 ();
    mux_sel_arbiter_if bus1 ();

    mux_sel_arbiter #(.BURST_LEN(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    mux_sel_arbiter #(.BURST_LEN(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // Multiplexer model
    assign bus4.mux_val = mux_in[bus4.sel];
    assign bus1.mux_val = mux_in[bus1.sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out4(input string tag, input logic [1:0] sel,
                              input logic [3:0] grant, input logic valid);
        check({tag, ".sel"},   {6'd0, bus4.sel},   {6'd0, sel});
        check({tag, ".grant"}, {4'd0, bus4.grant}, {4'd0, grant});
        check({tag, ".valid"}, {7'd0, bus4.valid}, {7'd0, valid});
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        mux_in[0] = 8'h0a;
        mux_in[1] = 8'h0b;
        mux_in[2] = 8'h0c;
        mux_in[3] = 8'h0d;
        bus4.req   = 4'b0000;
        bus4.ready = 1'b1;
        bus1.req   = 4'b0000;
        bus1.ready = 1'b1;
        rst = 1'b1;

        // ---------------- Reset ----------------
        tick();
        tick();
        check_out4("rst_hold", 2'd0, 4'b0000, 1'b0);
        check("rst_hold.data", bus4.data_out, 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out4("rst_idle", 2'd0, 4'b0000, 1'b0);
            check("rst_idle.data", bus4.data_out, 8'h00);
            check("rst_idle.valid1", {7'd0, bus1.valid}, 8'h00);
        end

        // ---------------- Single burst on channel 2 ----------------
        bus4.req = 4'b0100;
        tick();                                   // IDLE -> SETUP
        check_out4("burst_setup", 2'd2, 4'b0100, 1'b0);
        tick();                                   // SETUP -> XFER
        for (int i = 0; i < 4; i++) begin
            check_out4("burst_beat", 2'd2, 4'b0100, 1'b1);
            check("burst_beat.data", bus4.data_out, 8'h0c);
            tick();
        end
        // 4th beat accepted: sole requester re-granted via one SETUP cycle
        check_out4("burst_regrant", 2'd2, 4'b0100, 1'b0);
        bus4.req = 4'b0000;                       // drop during SETUP
        tick();
        check_out4("burst_drop_beat", 2'd2, 4'b0100, 1'b1);
        check("burst_drop_beat.data", bus4.data_out, 8'h0c);
        tick();
        check_out4("burst_idle", 2'd2, 4'b0000, 1'b0);

        // ---------------- Backpressure on channel 1 ----------------
        bus4.req = 4'b0010;
        tick();
        check_out4("bp_setup", 2'd1, 4'b0010, 1'b0);
        tick();
        check("bp_first.data", bus4.data_out, 8'h0b);
        bus4.ready = 1'b0;
        mux_in[1]  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out4("bp_stall", 2'd1, 4'b0010, 1'b1);
            check("bp_stall.data", bus4.data_out, 8'h0b);
        end
        bus4.ready = 1'b1;
        // three more beats (beats 2..4) must follow, then regrant SETUP
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out4("bp_resume", 2'd1, 4'b0010, 1'b1);
            check("bp_resume.data", bus4.data_out, 8'h55);
        end
        tick();
        check_out4("bp_end", 2'd1, 4'b0010, 1'b0);
        bus4.req  = 4'b0000;
        mux_in[1] = 8'h0b;
        tick();
        check("bp_tail.data", bus4.data_out, 8'h0b);
        tick();
        check_out4("bp_idle", 2'd1, 4'b0000, 1'b0);

        // ---------------- Early drop on channel 3 ----------------
        bus4.req = 4'b1000;
        tick();
        check_out4("drop_setup", 2'd3, 4'b1000, 1'b0);
        bus4.req = 4'b0001;                       // req[3] gone, req[0] pending
        tick();
        check_out4("drop_beat", 2'd3, 4'b1000, 1'b1);
        check("drop_beat.data", bus4.data_out, 8'h0d);
        tick();
        check_out4("drop_next", 2'd0, 4'b0001, 1'b0);
        bus4.req = 4'b0000;
        tick();
        check("drop_next.data", bus4.data_out, 8'h0a);
        tick();
        check_out4("drop_idle", 2'd0, 4'b0000, 1'b0);

        // ---------------- Async reset mid-burst ----------------
        bus4.req = 4'b0010;
        tick();
        tick();
        check_out4("arst_pre", 2'd1, 4'b0010, 1'b1);
        #2;
        rst = 1'b1;
        bus4.req = 4'b1001;
        #1;
        check_out4("arst_now", 2'd0, 4'b0000, 1'b0);
        check("arst_now.data", bus4.data_out, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_out4("arst_rearb", 2'd0, 4'b0001, 1'b0);
        bus4.req = 4'b0000;

        // ---------------- Round-robin, BURST_LEN = 1 ----------------
        bus1.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            logic [1:0] exp_sel;
            exp_sel = 2'(i);
            tick();
            check("rr_setup.sel",   {6'd0, bus1.sel},   {6'd0, exp_sel});
            check("rr_setup.valid", {7'd0, bus1.valid}, 8'h00);
            tick();
            check("rr_beat.valid", {7'd0, bus1.valid}, 8'h01);
            check("rr_beat.data",  bus1.data_out, mux_in[exp_sel]);
        end
        bus1.req = 4'b0000;
        tick();
        tick();
        check("rr_end.valid", {7'd0, bus1.valid}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_sel_arbiter.md
# mux_sel_arbiter

Round-robin source arbiter that drives the select of the 8-bit 4:1 `Multiplexer` stage and registers its output into a valid/ready stream. Four requesters raise `Req`. The block grants one requester at a time and steers `Sel` to it. It samples the mux output `ValOut`, returned here on `MuxVal`, and presents it downstream as bursts of up to `BURST_LEN` beats per grant.

## Interface
- `BURST_LEN`, default 4: maximum accepted beats per grant. Legal range is 1..15.
- `Clk` input, 1 bit: sole clock; all state changes on the rising edge.
- `Rst` input, 1 bit: reset, asynchronous, active-high.
- `Req` input, 4 bits: per-channel request. Bit i maps to mux input i: A=0, B=1, C=2, D=3.
- `MuxVal` input, 8 bits: `ValOut` of the downstream `Multiplexer`.
- `Ready` input, 1 bit: downstream consumer accepts `DataOut` when `Valid` and `Ready` are both high.
- `Sel` output, 2 bits: registered select, wired to the `Multiplexer` `Sel`.
- `Grant` output, 4 bits: one-hot current grant, or 0 when no grant.
- `Valid` output, 1 bit: `DataOut` holds a beat.
- `DataOut` output, 8 bits: registered copy of `MuxVal` for the granted channel.

## Operation
- Reset values:
  - State = IDLE.
  - `Sel` = 2'b00.
  - `Grant` = 4'b0000.
  - `Valid` = 0.
  - `DataOut` = 8'h00.
  - Last-granted pointer = 3, so channel 0 has first priority.
  - Beat counter = 0.
- States:
  - **IDLE**: `Valid` = 0, `Grant` = 0, `Sel` holds its last value. If any `Req` bit is high, arbitrate and go to SETUP. Otherwise stay.
  - **SETUP**: `Grant` is one-hot on the winner and `Sel` = winner index. `Valid` = 0. The mux settles this cycle. Next edge: load `DataOut` from `MuxVal`, set `Valid`, clear the beat counter, go to XFER.
  - **XFER**: `Grant` and `Sel` are held and `Valid` = 1.
    - On accept (`Valid` and `Ready`), increment the beat counter.
    - If the counter reaches `BURST_LEN` or `Req[granted]` = 0, the beat is the final beat:
      - If any `Req` bit is high, arbitrate and go to SETUP.
      - Otherwise go to IDLE, with `Valid` = 0 and `Grant` = 0.
    - If the beat is not final, reload `DataOut` from `MuxVal` and stay in XFER with `Valid` = 1.
- Arbitration:
  - Search order starts at (last + 1) mod 4 and wraps through 3 → 0.
  - The first set `Req` bit wins. The winner's index becomes the new last pointer.
  - A sole requester may be re-granted to itself after its burst ends.
- Stall: while `Valid` = 1 and `Ready` = 0, `DataOut`, `Sel`, `Grant` and the counter hold their values. `MuxVal` changes are ignored.
- `Req[granted]` falling during SETUP or during a stalled beat does not cancel the beat. At least one beat is always delivered per grant.
- `Req` bits other than the granted one have no effect until arbitration.
- Beat counter width is 4 bits. It compares equal to `BURST_LEN` and never wraps.

## Timing
- A `Req` sampled high in IDLE at edge N:
  - SETUP is active in cycle N+1.
  - `Valid` rises at edge N+2, with `DataOut` = `MuxVal` sampled at that edge.
- With `Ready` held high, a burst gives 1 beat per cycle. Total cycles per grant = `BURST_LEN` + 1 (one SETUP cycle).
- Grant switch with other requests pending: exactly 1 cycle of `Valid` = 0 (SETUP) between bursts. There is no IDLE cycle.
- `Rst` asserted at any time forces the reset values immediately (asynchronous), including mid-burst. An unaccepted beat is discarded.
- The first arbitration after `Rst` deasserts happens on the first rising edge with `Rst` low.

## Test plan
- **Reset**: drive `Req` = 0 and `Ready` = 1, then pulse `Rst` → `Sel` = 0, `Grant` = 0, `Valid` = 0 and `DataOut` = 0, holding through 5 idle cycles.
- **Single burst**: mux inputs A..D = 8'h0a/0b/0c/0d; `BURST_LEN` = 4; `Req` = 4'b0100; `Ready` = 1.
  - `Grant` = 4'b0100, `Sel` = 2'b10.
  - `Valid` rises 2 cycles after `Req`.
  - 4 beats of 8'h0c, then `Grant` re-asserts to 4'b0100 after 1 SETUP cycle.
- **Round-robin**: `Req` = 4'b1111, `Ready` = 1, `BURST_LEN` = 1 → `Sel` sequence 0, 1, 2, 3, 0; `DataOut` sequence 0a, 0b, 0c, 0d, 0a; one bubble between beats.
- **Backpressure**: during a burst on channel 1, hold `Ready` = 0 for 3 cycles while changing input B to 8'h55 → `DataOut` stays 8'h0b and the counter is unchanged. After `Ready` = 1, the next beat = 8'h55.
- **Early drop**: `Req[3]` granted, then `Req[3]` deasserted in SETUP → exactly 1 beat of 8'h0d is delivered, then IDLE (or SETUP if other `Req` bits are set).
- **Async reset mid-burst**: assert `Rst` between edges while `Valid` = 1 → all outputs at reset values before the next edge. After release, channel 0 wins with `Req` = 4'b1001.
